// File: rtl/tlb_op_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl_if
// Instruction handshake between the commit stage (master) and the TLB
// maintenance sequencer (slave).
//   op_valid / op_ready : request handshake, accepted when both are high
//   op_code             : 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 no-op
//   inv_op/asid/vpn     : INVTLB operands
//   op_done             : one-cycle completion pulse from the sequencer
// ---------------------------------------------------------------------------
interface tlb_op_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vpn;
  logic        op_done;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vpn,
    input  op_ready, op_done
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vpn,
    output op_ready, op_done
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl
// Sequencer for the LoongArch32 TLB maintenance instructions (TLBSRCH, TLBRD,
// TLBWR, TLBFILL, INVTLB). Accepts one instruction at a time from commit,
// runs the array access and produces the TLB CSR update strobes.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   op_bus                : instruction handshake and INVTLB operands
//   csr_index, csr_vpn    : TLBIDX.Index and TLBEHI.VPN, captured on accept
//   exc_vld               : exception is writing TLBEHI this cycle
//   srch_vpn/hit/idx      : search key out, combinational search result in
//   rd_idx, rd_e/g/asid/vpn : array read index out, entry fields in
//   tlb_we, tlb_widx      : array write strobe and index
//   inv_en                : clear E bit of entry rd_idx
//   TLBRD_en, TLB_VPN     : TLBEHI load from TLBRD
//   idx_we/ne/index       : TLBIDX update
// ---------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tlb_op_ctrl_if.slave      op_bus,
  input  logic [IDX_W-1:0]  csr_index,
  input  logic [18:0]       csr_vpn,
  input  logic              exc_vld,
  output logic [18:0]       srch_vpn,
  input  logic              srch_hit,
  input  logic [IDX_W-1:0]  srch_idx,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_e,
  input  logic              rd_g,
  input  logic [9:0]        rd_asid,
  input  logic [18:0]       rd_vpn,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_widx,
  output logic              inv_en,
  output logic              TLBRD_en,
  output logic [18:0]       TLB_VPN,
  output logic              idx_we,
  output logic              idx_ne,
  output logic [IDX_W-1:0]  idx_index,
  output logic              op_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_RD,
    ST_WR,
    ST_INV,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [18:0]      vpn_q, vpn_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       inv_asid_q, inv_asid_d;
  logic [18:0]      inv_vpn_q, inv_vpn_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic [IDX_W-1:0] walk_q, walk_d;

  logic             asid_match;
  logic             vpn_match;
  logic             inv_match;

  assign op_done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      vpn_q      <= '0;
      widx_q     <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
      rand_q     <= '0;
      walk_q     <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      vpn_q      <= vpn_d;
      widx_q     <= widx_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vpn_q  <= inv_vpn_d;
      rand_q     <= rand_d;
      walk_q     <= walk_d;
    end
  end

  // INVTLB selection rule for the entry currently on rd_idx.
  always_comb begin
    asid_match = (rd_asid == inv_asid_q);
    vpn_match  = (rd_vpn == inv_vpn_q);
    inv_match  = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_match = 1'b1;
      5'd2:       inv_match = rd_g;
      5'd3:       inv_match = ~rd_g;
      5'd4:       inv_match = ~rd_g & asid_match;
      5'd5:       inv_match = ~rd_g & asid_match & vpn_match;
      5'd6:       inv_match = (rd_g | asid_match) & vpn_match;
      default:    inv_match = 1'b0;
    endcase
  end

  // Next-state and strobe logic. Outputs that carry indices or keys default
  // to captured registers so they read zero out of reset; the rand counter
  // wraps naturally because TLB_NUM is a power of two.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    vpn_d      = vpn_q;
    widx_d     = widx_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vpn_d  = inv_vpn_q;
    rand_d     = rand_q + IDX_W'(1);
    walk_d     = walk_q;

    op_bus.op_ready = (state_q == ST_IDLE);
    srch_vpn        = vpn_q;
    rd_idx          = (state_q == ST_INV) ? walk_q : index_q;
    tlb_we          = 1'b0;
    tlb_widx        = widx_q;
    inv_en          = 1'b0;
    TLBRD_en        = 1'b0;
    TLB_VPN         = '0;
    idx_we          = 1'b0;
    idx_ne          = 1'b0;
    idx_index       = index_q;

    unique case (state_q)
      ST_IDLE: begin
        if (op_bus.op_valid) begin
          index_d    = csr_index;
          vpn_d      = csr_vpn;
          inv_op_d   = op_bus.inv_op;
          inv_asid_d = op_bus.inv_asid;
          inv_vpn_d  = op_bus.inv_vpn;
          walk_d     = '0;
          // FILL writes the slot chosen by the rand counter at accept time.
          widx_d     = (op_bus.op_code == 3'd3) ? rand_q : csr_index;
          case (op_bus.op_code)
            3'd0:       state_d = ST_SRCH;
            3'd1:       state_d = ST_RD;
            3'd2, 3'd3: state_d = ST_WR;
            3'd4:       state_d = ST_INV;
            default:    state_d = ST_DONE;
          endcase
        end
      end

      ST_SRCH: begin
        if (!exc_vld) begin
          idx_we = 1'b1;
          idx_ne = ~srch_hit;
          if (srch_hit) begin
            idx_index = srch_idx;
          end
        end
        state_d = ST_DONE;
      end

      ST_RD: begin
        // An exception in this cycle owns TLBEHI, so the read is dropped.
        if (!exc_vld) begin
          idx_we = 1'b1;
          if (rd_e) begin
            TLBRD_en = 1'b1;
            TLB_VPN  = rd_vpn;
          end else begin
            idx_ne = 1'b1;
          end
        end
        state_d = ST_DONE;
      end

      ST_WR: begin
        tlb_we  = 1'b1;
        state_d = ST_DONE;
      end

      ST_INV: begin
        if (exc_vld) begin
          walk_d  = '0;
          state_d = ST_DONE;
        end else begin
          inv_en = rd_e & inv_match;
          if (walk_q == LAST_IDX) begin
            walk_d  = '0;
            state_d = ST_DONE;
          end else begin
            walk_d = walk_q + IDX_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign op_bus.op_done = op_done;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlb_op_ctrl
// Self-checking bench for tlb_op_ctrl. A cycle-offset model of each accepted
// instruction predicts every strobe; directed operations pin the model with
// hand-computed values, then randomized traffic runs against it.
// ---------------------------------------------------------------------------
module tb_tlb_op_ctrl;
  localparam int TLB_NUM = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_op_ctrl_if op_if();

  logic [IDX_W-1:0] csr_index;
  logic [18:0]      csr_vpn;
  logic             exc_vld;
  logic [18:0]      srch_vpn;
  logic             srch_hit;
  logic [IDX_W-1:0] srch_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_e;
  logic             rd_g;
  logic [9:0]       rd_asid;
  logic [18:0]      rd_vpn;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_widx;
  logic             inv_en;
  logic             TLBRD_en;
  logic [18:0]      TLB_VPN;
  logic             idx_we;
  logic             idx_ne;
  logic [IDX_W-1:0] idx_index;
  logic             op_done;

  // Simple TLB array environment answering reads combinationally.
  bit          arr_e[TLB_NUM];
  bit          arr_g[TLB_NUM];
  logic [9:0]  arr_asid[TLB_NUM];
  logic [18:0] arr_vpn[TLB_NUM];

  assign rd_e    = arr_e[rd_idx];
  assign rd_g    = arr_g[rd_idx];
  assign rd_asid = arr_asid[rd_idx];
  assign rd_vpn  = arr_vpn[rd_idx];

  tlb_op_ctrl #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_bus    (op_if),
    .csr_index (csr_index),
    .csr_vpn   (csr_vpn),
    .exc_vld   (exc_vld),
    .srch_vpn  (srch_vpn),
    .srch_hit  (srch_hit),
    .srch_idx  (srch_idx),
    .rd_idx    (rd_idx),
    .rd_e      (rd_e),
    .rd_g      (rd_g),
    .rd_asid   (rd_asid),
    .rd_vpn    (rd_vpn),
    .tlb_we    (tlb_we),
    .tlb_widx  (tlb_widx),
    .inv_en    (inv_en),
    .TLBRD_en  (TLBRD_en),
    .TLB_VPN   (TLB_VPN),
    .idx_we    (idx_we),
    .idx_ne    (idx_ne),
    .idx_index (idx_index),
    .op_done   (op_done)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: an accepted op is described by its kind and the
  // number of clock edges since acceptance. Work cycles are 1..done_t-1 and
  // op_done is cycle done_t; an exception in an abortable work cycle pulls
  // done_t in to the following cycle.
  bit m_busy = 1'b0;
  int m_kind, m_t, m_done_t;
  int m_index, m_cvpn, m_fill, m_iop, m_iasid, m_ivpn;
  int m_rand = 0;

  int e_ready, e_done, e_we, e_inv, e_rden, e_idxwe, e_ne, e_tvpn, e_index, e_widx, e_rdidx;
  bit chk_rdidx, chk_srch;

  function automatic bit invMatch(int iop, bit g, bit am, bit vm);
    case (iop)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && am;
      5:       return !g && am && vm;
      6:       return (g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    int w;
    e_ready = 1; e_done = 0; e_we = 0; e_inv = 0; e_rden = 0; e_idxwe = 0;
    e_ne = 0; e_tvpn = 0; e_index = 0; e_widx = 0; e_rdidx = 0;
    chk_rdidx = 1'b0; chk_srch = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rand = 0;
      checkOutput("rst_ready", 32'(op_if.op_ready), 1);
      checkOutput("rst_done", 32'(op_done), 0);
      checkOutput("rst_strobes", {27'd0, tlb_we, inv_en, TLBRD_en, idx_we, idx_ne}, 0);
      checkOutput("rst_tlb_vpn", 32'(TLB_VPN), 0);
      checkOutput("rst_idx_index", 32'(idx_index), 0);
      checkOutput("rst_rd_idx", 32'(rd_idx), 0);
      checkOutput("rst_tlb_widx", 32'(tlb_widx), 0);
      checkOutput("rst_srch_vpn", 32'(srch_vpn), 0);
    end else begin
      if (m_busy) begin
        e_ready = 0;
        if (m_t == m_done_t) begin
          e_done = 1;
        end else begin
          case (m_kind)
            0: begin
              chk_srch = 1'b1;
              if (!exc_vld) begin
                e_idxwe = 1;
                e_ne    = srch_hit ? 0 : 1;
                e_index = srch_hit ? int'(srch_idx) : m_index;
              end
            end
            1: begin
              chk_rdidx = 1'b1;
              e_rdidx   = m_index;
              if (!exc_vld) begin
                e_idxwe = 1;
                e_index = m_index;
                if (arr_e[m_index]) begin
                  e_rden = 1;
                  e_tvpn = int'(arr_vpn[m_index]);
                end else begin
                  e_ne = 1;
                end
              end
            end
            2, 3: begin
              e_we   = 1;
              e_widx = (m_kind == 3) ? m_fill : m_index;
            end
            4: begin
              w         = m_t - 1;
              chk_rdidx = 1'b1;
              e_rdidx   = w;
              if (!exc_vld && arr_e[w] &&
                  invMatch(m_iop, arr_g[w], int'(arr_asid[w]) == m_iasid, int'(arr_vpn[w]) == m_ivpn))
                e_inv = 1;
            end
            default: ;
          endcase
        end
      end

      checkOutput("op_ready", 32'(op_if.op_ready), e_ready);
      checkOutput("op_done", 32'(op_done), e_done);
      checkOutput("tlb_we", 32'(tlb_we), e_we);
      checkOutput("inv_en", 32'(inv_en), e_inv);
      checkOutput("TLBRD_en", 32'(TLBRD_en), e_rden);
      checkOutput("TLB_VPN", 32'(TLB_VPN), e_tvpn);
      checkOutput("idx_we", 32'(idx_we), e_idxwe);
      checkOutput("idx_ne", 32'(idx_ne), e_ne);
      if (e_idxwe != 0) checkOutput("idx_index", 32'(idx_index), e_index);
      if (e_we != 0)    checkOutput("tlb_widx", 32'(tlb_widx), e_widx);
      if (chk_rdidx)    checkOutput("rd_idx", 32'(rd_idx), e_rdidx);
      if (chk_srch)     checkOutput("srch_vpn", 32'(srch_vpn), m_cvpn);

      // Array side effect of an invalidate strobe.
      if (inv_en === 1'b1) arr_e[rd_idx] = 1'b0;

      if (m_busy) begin
        if (m_t == m_done_t) begin
          m_busy = 1'b0;
        end else begin
          if (exc_vld && (m_kind == 0 || m_kind == 1 || m_kind == 4))
            m_done_t = m_t + 1;
          m_t++;
        end
      end else if (op_if.op_valid === 1'b1) begin
        m_busy   = 1'b1;
        m_t      = 1;
        m_kind   = (op_if.op_code <= 3'd4) ? int'(op_if.op_code) : 5;
        m_done_t = (m_kind == 4) ? TLB_NUM + 1 : (m_kind == 5) ? 1 : 2;
        m_index  = int'(csr_index);
        m_cvpn   = int'(csr_vpn);
        m_fill   = m_rand;
        m_iop    = int'(op_if.inv_op);
        m_iasid  = int'(op_if.inv_asid);
        m_ivpn   = int'(op_if.inv_vpn);
      end
      m_rand = (m_rand + 1) % TLB_NUM;
    end
  end

  // Results of the last directed operation.
  int r_done, r_inv_cnt, r_inv_first, r_we_cnt, r_widx, r_rd_cnt, r_rd_vpn;
  int r_idxwe_cnt, r_ne, r_index;

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_op_ready", 32'(op_if.op_ready), 1);
    checkOutput("reset_tlb_vpn", 32'(TLB_VPN), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic runOp(input int code, input int idx, input int vpn, input int iop,
                       input int iasid, input int ivpn, input int exc_cyc,
                       input bit hit, input int hidx);
    int guard;
    int n;
    @(posedge clk); #1;
    guard = 0;
    while (op_if.op_ready !== 1'b1 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 64) checkOutput("ready_timeout", 0, 1);
    op_if.op_valid = 1'b1;
    op_if.op_code  = 3'(code);
    op_if.inv_op   = 5'(iop);
    op_if.inv_asid = 10'(iasid);
    op_if.inv_vpn  = 19'(ivpn);
    csr_index      = IDX_W'(idx);
    csr_vpn        = 19'(vpn);
    srch_hit       = hit;
    srch_idx       = IDX_W'(hidx);
    exc_vld        = 1'b0;
    r_done = 0; r_inv_cnt = 0; r_inv_first = -1; r_we_cnt = 0; r_widx = -1;
    r_rd_cnt = 0; r_rd_vpn = -1; r_idxwe_cnt = 0; r_ne = -1; r_index = -1;
    @(posedge clk); #1;
    op_if.op_valid = 1'b0;
    n = 1;
    exc_vld = (exc_cyc == 1);
    while (1) begin
      @(negedge clk);
      if (TLBRD_en === 1'b1) begin r_rd_cnt++; r_rd_vpn = int'(TLB_VPN); end
      if (idx_we === 1'b1)   begin r_idxwe_cnt++; r_ne = int'(idx_ne); r_index = int'(idx_index); end
      if (tlb_we === 1'b1)   begin r_we_cnt++; r_widx = int'(tlb_widx); end
      if (inv_en === 1'b1)   begin
        if (r_inv_cnt == 0) r_inv_first = int'(rd_idx);
        r_inv_cnt++;
      end
      if (op_done === 1'b1) begin r_done = n; break; end
      if (n >= 64) begin checkOutput("done_timeout", 0, 1); break; end
      @(posedge clk); #1;
      n++;
      exc_vld = (exc_cyc == n);
    end
  endtask

  task automatic clearArray();
    for (int i = 0; i < TLB_NUM; i++) begin
      arr_e[i] = 1'b0; arr_g[i] = 1'b0; arr_asid[i] = '0; arr_vpn[i] = '0;
    end
  endtask

  task automatic applyStimulus();
    int k;
    op_if.op_valid = ($urandom_range(0, 1) == 1);
    op_if.op_code  = 3'($urandom_range(0, 7));
    op_if.inv_op   = 5'($urandom_range(0, 8));
    op_if.inv_asid = ($urandom_range(0, 1) == 1) ? 10'h2A : 10'h15;
    op_if.inv_vpn  = ($urandom_range(0, 1) == 1) ? 19'h00100 : 19'h00200;
    csr_index      = IDX_W'($urandom_range(0, TLB_NUM - 1));
    csr_vpn        = 19'($urandom);
    exc_vld        = ($urandom_range(0, 15) == 0);
    srch_hit       = ($urandom_range(0, 1) == 1);
    srch_idx       = IDX_W'($urandom_range(0, TLB_NUM - 1));
    k = $urandom_range(0, TLB_NUM - 1);
    arr_e[k]    = ($urandom_range(0, 3) != 0);
    arr_g[k]    = ($urandom_range(0, 1) == 1);
    arr_asid[k] = ($urandom_range(0, 1) == 1) ? 10'h2A : 10'h15;
    arr_vpn[k]  = ($urandom_range(0, 1) == 1) ? 19'h00100 : 19'h00200;
  endtask

  initial begin
    op_if.op_valid = 1'b0; op_if.op_code = '0; op_if.inv_op = '0;
    op_if.inv_asid = '0; op_if.inv_vpn = '0;
    csr_index = '0; csr_vpn = '0; exc_vld = 1'b0; srch_hit = 1'b0; srch_idx = '0;
    clearArray();

    doReset();

    // TLBRD of a valid entry.
    arr_e[3] = 1'b1; arr_vpn[3] = 19'h12345;
    runOp(1, 3, 0, 0, 0, 0, 0, 1'b0, 0);
    checkOutput("rd_tlbrd_count", r_rd_cnt, 1);
    checkOutput("rd_tlb_vpn", r_rd_vpn, 32'h12345);
    checkOutput("rd_idx_we_count", r_idxwe_cnt, 1);
    checkOutput("rd_idx_ne", r_ne, 0);
    checkOutput("rd_done_cycle", r_done, 2);

    // TLBRD aborted by an exception in the read cycle.
    runOp(1, 3, 0, 0, 0, 0, 1, 1'b0, 0);
    checkOutput("rdexc_tlbrd_count", r_rd_cnt, 0);
    checkOutput("rdexc_idx_we_count", r_idxwe_cnt, 0);
    checkOutput("rdexc_done_cycle", r_done, 2);

    // TLBSRCH miss keeps the index, then hit reports index 9.
    runOp(0, 5, 19'h0ABCD, 0, 0, 0, 0, 1'b0, 2);
    checkOutput("srch_miss_ne", r_ne, 1);
    checkOutput("srch_miss_index", r_index, 5);
    runOp(0, 5, 19'h0ABCD, 0, 0, 0, 0, 1'b1, 9);
    checkOutput("srch_hit_ne", r_ne, 0);
    checkOutput("srch_hit_index", r_index, 9);

    // TLBFILL accepted on the 21st edge after reset: rand counter holds 20 mod 16.
    doReset();
    repeat (19) @(posedge clk);
    runOp(3, 7, 0, 0, 0, 0, 0, 1'b0, 0);
    checkOutput("fill_we_count", r_we_cnt, 1);
    checkOutput("fill_widx", r_widx, 4);
    checkOutput("fill_done_cycle", r_done, 2);

    // TLBWR ignores exceptions.
    runOp(2, 11, 0, 0, 0, 0, 1, 1'b0, 0);
    checkOutput("wr_exc_we_count", r_we_cnt, 1);
    checkOutput("wr_exc_widx", r_widx, 11);

    // INVTLB op 5: only the non-global matching entry is cleared.
    clearArray();
    arr_e[2] = 1'b1; arr_g[2] = 1'b0; arr_asid[2] = 10'h2A; arr_vpn[2] = 19'h00100;
    arr_e[7] = 1'b1; arr_g[7] = 1'b1; arr_asid[7] = 10'h2A; arr_vpn[7] = 19'h00100;
    arr_e[4] = 1'b1; arr_g[4] = 1'b0; arr_asid[4] = 10'h2A; arr_vpn[4] = 19'h00200;
    runOp(4, 0, 0, 5, 10'h2A, 19'h00100, 0, 1'b0, 0);
    checkOutput("inv5_count", r_inv_cnt, 1);
    checkOutput("inv5_index", r_inv_first, 2);
    checkOutput("inv5_done_cycle", r_done, 17);
    checkOutput("inv5_entry7_kept", 32'(arr_e[7]), 1);

    // INVTLB with an unsupported op walks the whole array without clearing.
    for (int i = 0; i < TLB_NUM; i++) arr_e[i] = 1'b1;
    runOp(4, 0, 0, 9, 0, 0, 0, 1'b0, 0);
    checkOutput("inv9_count", r_inv_cnt, 0);
    checkOutput("inv9_done_cycle", r_done, 17);
    @(negedge clk);
    checkOutput("inv9_done_single", 32'(op_done), 0);

    // INVTLB op 0 aborted at cycle 5 after clearing entries 0..3.
    runOp(4, 0, 0, 0, 0, 0, 5, 1'b0, 0);
    checkOutput("invabort_count", r_inv_cnt, 4);
    checkOutput("invabort_done_cycle", r_done, 6);
    checkOutput("invabort_entry4_kept", 32'(arr_e[4]), 1);

    // Unused op code goes straight to completion.
    runOp(6, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    checkOutput("nop_done_cycle", r_done, 1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      applyStimulus();
    end
    @(posedge clk); #1;
    op_if.op_valid = 1'b0;
    exc_vld = 1'b0;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the LoongArch32 TLB-maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB). It sits between the commit stage and the TLB entry array / TLB CSRs. It accepts one instruction at a time over a valid/ready handshake and runs the multi-cycle array access. It also produces the CSR update strobes, including the TLBRD_en / TLB_VPN pair consumed by the TLBEHI register, and arbitrates those strobes against exception-driven TLBEHI updates.

## Interface
- TLB_NUM, 16, number of TLB entries (power of two, 4..64)
- IDX_W, 4, log2(TLB_NUM)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  instruction request from commit
- op_ready  out  1  controller idle, request accepted when op_valid&op_ready
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 treated as no-op
- inv_op  in  5  INVTLB op field
- inv_asid  in  10  INVTLB ASID operand
- inv_vpn  in  19  INVTLB VA[31:13] operand
- csr_index  in  IDX_W  TLBIDX.Index
- csr_vpn  in  19  TLBEHI.VPN
- exc_vld  in  1  TLB-related exception writing TLBEHI this cycle
- srch_vpn  out  19  search key to array (=captured csr_vpn)
- srch_hit  in  1  array search hit (combinational)
- srch_idx  in  IDX_W  hit index
- rd_idx  out  IDX_W  array read index
- rd_e, rd_g  in  1 each  entry E and G bits at rd_idx (combinational)
- rd_asid  in  10  entry ASID
- rd_vpn  in  19  entry VPPN
- tlb_we  out  1  array write strobe (entry data comes from CSRs)
- tlb_widx  out  IDX_W  write index
- inv_en  out  1  clear E of entry rd_idx this cycle
- TLBRD_en  out  1  load TLB_VPN into TLBEHI
- TLB_VPN  out  19  VPN for TLBEHI
- idx_we  out  1  update TLBIDX
- idx_ne  out  1  TLBIDX.NE value
- idx_index  out  IDX_W  TLBIDX.Index value
- op_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SRCH, RD, WR, INV, DONE. op_ready=1 only in IDLE. Operands are captured into registers on acceptance.
- op_code 0: IDLE->SRCH.
  - SRCH drives srch_vpn and samples srch_hit/srch_idx.
  - It pulses idx_we with idx_ne=~srch_hit. idx_index=srch_idx on hit, otherwise unchanged (driven as captured csr_index).
  - Next state DONE.
- op_code 1: IDLE->RD with rd_idx=captured csr_index.
  - If rd_e: TLBRD_en=1, TLB_VPN=rd_vpn, idx_we=1, idx_ne=0.
  - Else: idx_we=1, idx_ne=1, TLBRD_en=0.
  - Next state DONE.
- op_code 2/3: IDLE->WR.
  - tlb_we=1 for one cycle.
  - tlb_widx=csr_index for WR; tlb_widx=random counter value captured at acceptance for FILL.
  - Next state DONE.
- Random counter: IDX_W-bit free-running up-counter. Increments every cycle, wraps TLB_NUM-1->0, reset 0.
- op_code 4: IDLE->INV. An IDX_W walk counter steps 0..TLB_NUM-1, one entry per cycle, with rd_idx=walk counter. inv_en=1 when rd_e and the match rule holds:
  - op 0/1: all entries
  - op 2: G=1
  - op 3: G=0
  - op 4: G=0 & asid match
  - op 5: G=0 & asid match & vpn match
  - op 6: (G=1 | asid match) & vpn match
  - inv_op>6: no entry cleared, walk still completes
- INV leaves to DONE after entry TLB_NUM-1; the walk counter wraps to 0.
- op_code 5-7: IDLE->DONE directly.
- DONE: op_done=1, return to IDLE.
- exc_vld priority:
  - In any cycle with exc_vld=1, TLBRD_en is forced 0 (the exception VPN wins TLBEHI).
  - If exc_vld=1 in SRCH, RD or INV, the operation aborts: no idx_we/inv_en/TLBRD_en that cycle, go to DONE. Entries already cleared stay cleared.
  - WR completes regardless of exc_vld.
- Reset mid-operation: return to IDLE, all state and counters cleared, no strobes.

## Timing
- Reset values: op_ready=1, all strobes 0, TLB_VPN=0, idx_index=0, idx_ne=0, rd_idx=0, tlb_widx=0, srch_vpn=0.
- Acceptance edge is cycle 0. Work cycle is cycle 1 for SRCH/RD/WR, cycles 1..TLB_NUM for INV. op_done follows in the next cycle. Next op_ready=1 the cycle after op_done.
- All CSR/array strobes are combinational from registered state plus same-cycle array responses. Each strobe asserts at most once per operation, except inv_en.
- Back-to-back: one instruction per (latency+2) cycles. op_valid held while op_ready=0 is ignored.

## Test plan
- Reset then TLBRD with csr_index=3, entry 3 E=1 VPPN=0x12345 -> cycle 1: TLBRD_en=1, TLB_VPN=0x12345, idx_we=1, idx_ne=0; op_done at cycle 2.
- TLBRD with exc_vld=1 in the RD cycle -> TLBRD_en=0, idx_we=0, op_done next cycle.
- TLBSRCH miss then hit at index 9 -> idx_ne=1 with index unchanged; then idx_ne=0, idx_index=9.
- TLBFILL accepted 20 cycles after reset with TLB_NUM=16 -> tlb_widx=4, single tlb_we pulse.
- INVTLB op 5, asid=0x2A, vpn=0x00100, entries 2 (G=0, match) and 7 (G=1, match) -> inv_en only at rd_idx=2; op_done at cycle 17.
- INVTLB inv_op=9 -> 16 walk cycles, inv_en never asserts, op_done pulses once.
